// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

  // Result-select codes; the codes 100-111 are not named and fall back to the ALU result.
  typedef enum logic [2:0] {
    SEL_ALU = 3'b000,
    SEL_MEM = 3'b001,
    SEL_PC4 = 3'b010,
    SEL_IMM = 3'b011
  } data_sel_e;

  // Load size/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Stage control state.
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts the addressed byte/halfword from a raw load word and extends it to XLEN.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Pick the lane, then sign- or zero-extend by funct3; addr_lo[0] is ignored for halfwords.
  always_comb begin
    byte_s = i_rdata[{i_addr_lo, 3'b000} +: 8];
    half_s = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LH:   o_data = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, half_s};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits one instruction per handshake, stalls on loads until the
// data-memory response arrives, drives the registered register-file write port and
// counts retired instructions.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_reg_write,
  input  logic [4:0]       i_rd_waddr,
  input  logic [2:0]       i_data_sel,
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_addr_lo,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc_plus4,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic             o_rd_wen,
  output logic [4:0]       o_rd_waddr,
  output logic [XLEN-1:0]  o_rd_wdata,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_instret
);

  state_e            state_q, state_d;
  logic              rd_wen_q, rd_wen_d;
  logic [4:0]        rd_waddr_q, rd_waddr_d;
  logic [XLEN-1:0]   rd_wdata_q, rd_wdata_d;
  logic              retire_q, retire_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  // Fields of a pending load, held while the memory response is outstanding.
  logic              hold_reg_write_q, hold_reg_write_d;
  logic [4:0]        hold_rd_q, hold_rd_d;
  logic [2:0]        hold_funct3_q, hold_funct3_d;
  logic [1:0]        hold_addr_lo_q, hold_addr_lo_d;

  logic              capture;
  logic              is_load;
  logic              load_done;
  logic [XLEN-1:0]   sel_value;
  logic [XLEN-1:0]   load_data;

  assign o_ready   = (state_q == IDLE);
  assign capture   = i_valid && o_ready;
  assign is_load   = (i_data_sel == SEL_MEM);
  // The response only counts once the load is actually outstanding.
  assign load_done = (state_q == WAIT_LOAD) && i_dmem_rvalid;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .i_rdata   (i_dmem_rdata),
    .i_funct3  (hold_funct3_q),
    .i_addr_lo (hold_addr_lo_q),
    .o_data    (load_data)
  );

  // Non-load result mux; unnamed select codes fall back to the ALU result.
  always_comb begin
    case (i_data_sel)
      SEL_PC4: sel_value = i_pc_plus4;
      SEL_IMM: sel_value = i_imm;
      default: sel_value = i_alu_result;
    endcase
  end

  // State register and all reset-visible outputs; reset drops any pending load.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      rd_wen_q   <= 1'b0;
      rd_waddr_q <= '0;
      rd_wdata_q <= '0;
      retire_q   <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_wen_q   <= rd_wen_d;
      rd_waddr_q <= rd_waddr_d;
      rd_wdata_q <= rd_wdata_d;
      retire_q   <= retire_d;
      instret_q  <= instret_d;
    end
  end

  // Holding register for load fields; pure data, so no reset.
  always_ff @(posedge i_clk) begin
    hold_reg_write_q <= hold_reg_write_d;
    hold_rd_q        <= hold_rd_d;
    hold_funct3_q    <= hold_funct3_d;
    hold_addr_lo_q   <= hold_addr_lo_d;
  end

  // Next state: a captured load waits for its response, everything else stays idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (capture && is_load) state_d = WAIT_LOAD;
      WAIT_LOAD: if (i_dmem_rvalid)      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Latch instruction fields on every handshake.
  always_comb begin
    hold_reg_write_d = hold_reg_write_q;
    hold_rd_d        = hold_rd_q;
    hold_funct3_d    = hold_funct3_q;
    hold_addr_lo_d   = hold_addr_lo_q;
    if (capture) begin
      hold_reg_write_d = i_reg_write;
      hold_rd_d        = i_rd_waddr;
      hold_funct3_d    = i_funct3;
      hold_addr_lo_d   = i_addr_lo;
    end
  end

  // Commit outputs: non-loads commit the cycle after capture, loads the cycle after rvalid.
  always_comb begin
    rd_wen_d   = 1'b0;
    retire_d   = 1'b0;
    rd_waddr_d = rd_waddr_q;
    rd_wdata_d = rd_wdata_q;
    instret_d  = instret_q;
    if (capture && !is_load) begin
      retire_d   = 1'b1;
      rd_wen_d   = i_reg_write && (i_rd_waddr != 5'd0);
      rd_waddr_d = i_rd_waddr;
      rd_wdata_d = sel_value;
    end else if (load_done) begin
      retire_d   = 1'b1;
      rd_wen_d   = hold_reg_write_q && (hold_rd_q != 5'd0);
      rd_waddr_d = hold_rd_q;
      rd_wdata_d = load_data;
    end
    if (retire_d) instret_d = instret_q + CNT_W'(1);
  end

  assign o_rd_wen   = rd_wen_q;
  assign o_rd_waddr = rd_waddr_q;
  assign o_rd_wdata = rd_wdata_q;
  assign o_retire   = retire_q;
  assign o_instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_reg_write = 1'b0;
  logic [4:0]  i_rd_waddr = '0;
  logic [2:0]  i_data_sel = '0;
  logic [2:0]  i_funct3 = '0;
  logic [1:0]  i_addr_lo = '0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_pc_plus4 = '0;
  logic [31:0] i_imm = '0;
  logic        i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic        o_rd_wen;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
  logic        o_retire;
  logic [63:0] o_instret;

  int total = 0;
  int bad = 0;
  longint unsigned exp_instret = 0;

  wb_stage dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_reg_write  (i_reg_write),
    .i_rd_waddr   (i_rd_waddr),
    .i_data_sel   (i_data_sel),
    .i_funct3     (i_funct3),
    .i_addr_lo    (i_addr_lo),
    .i_alu_result (i_alu_result),
    .i_pc_plus4   (i_pc_plus4),
    .i_imm        (i_imm),
    .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata (i_dmem_rdata),
    .o_rd_wen     (o_rd_wen),
    .o_rd_waddr   (o_rd_waddr),
    .o_rd_wdata   (o_rd_wdata),
    .o_retire     (o_retire),
    .o_instret    (o_instret)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_dmem_rvalid = 1'b0;
    step();
    step();
    i_rst = 1'b1;
    exp_instret = 0;
  endtask

  task automatic set_op(input logic [2:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [31:0] imm);
    i_data_sel = sel; i_funct3 = f3; i_addr_lo = lo; i_rd_waddr = rd;
    i_reg_write = rw; i_alu_result = alu; i_pc_plus4 = pc4; i_imm = imm;
  endtask

  // Capture a load, wait `delay` idle cycles, then deliver the response word.
  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                         input logic [31:0] word, input int delay);
    set_op(3'b001, f3, lo, rd, 1'b1, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (delay) step();
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = word;
    step();
    i_dmem_rvalid = 1'b0;
  endtask

  // Reference load extraction from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lo);
    longint v;
    longint unsigned w;
    int unsigned off;
    w = longint'(word);
    off = lo;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = longint'((w >> (8 * off)) % 256);
      if (f3 == 3'b000 && v >= 128) v = v - 256;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      off = off / 2;
      v = longint'((w >> (16 * off)) % 65536);
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  task automatic test_reset();
    apply_reset();
    total++;
    if ({o_ready, o_rd_wen, o_retire} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl: got ready/wen/retire=%b required 100", {o_ready, o_rd_wen, o_retire});
    end
    total++;
    if (o_rd_waddr !== 5'd0 || o_rd_wdata !== 32'd0 || o_instret !== 64'd0) begin
      bad++;
      $display("FAIL reset_data: got waddr=%0d wdata=%h instret=%0d required 0/0/0",
               o_rd_waddr, o_rd_wdata, o_instret);
    end
  endtask

  task automatic test_alu();
    apply_reset();
    set_op(3'b000, 3'b000, 2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    total++;
    if ({o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 1'b1, 5'd5, 32'h0000_1234}
        || o_instret !== 64'd1) begin
      bad++;
      $display("FAIL alu_commit: got retire=%b wen=%b rd=%0d data=%h instret=%0d required 1 1 5 00001234 1",
               o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata, o_instret);
    end
    step();
    total++;
    if ({o_retire, o_rd_wen} !== 2'b00 || o_rd_wdata !== 32'h0000_1234 || o_rd_waddr !== 5'd5) begin
      bad++;
      $display("FAIL alu_after: got retire=%b wen=%b rd=%0d data=%h required 0 0 5 00001234 (held)",
               o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    logic        exp_w [3];
    logic [4:0]  exp_r [3];
    apply_reset();
    exp_d[0] = 32'h0000_0104; exp_w[0] = 1'b1; exp_r[0] = 5'd3;
    exp_d[1] = 32'hABCD_E000; exp_w[1] = 1'b1; exp_r[1] = 5'd9;
    exp_d[2] = 32'h0000_0777; exp_w[2] = 1'b0; exp_r[2] = 5'd0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_op(3'b010, 3'b0, 2'd0, 5'd3, 1'b1, 32'h1, 32'h0000_0104, 32'h2);
        1: set_op(3'b011, 3'b0, 2'd0, 5'd9, 1'b1, 32'h1, 32'h2, 32'hABCD_E000);
        default: set_op(3'b000, 3'b0, 2'd0, 5'd0, 1'b1, 32'h0000_0777, 32'h2, 32'h3);
      endcase
      i_valid = 1'b1;
      step();
      total++;
      if ({o_ready, o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata} !==
          {1'b1, 1'b1, exp_w[k], exp_r[k], exp_d[k]} || o_instret !== 64'(k + 1)) begin
        bad++;
        $display("FAIL b2b_%0d: got ready=%b retire=%b wen=%b rd=%0d data=%h instret=%0d required 1 1 %b %0d %h %0d",
                 k, o_ready, o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata, o_instret,
                 exp_w[k], exp_r[k], exp_d[k], k + 1);
      end
    end
    i_valid = 1'b0;
    step();
    total++;
    if (o_retire !== 1'b0 || o_instret !== 64'd3) begin
      bad++;
      $display("FAIL b2b_idle: got retire=%b instret=%0d required 0 3", o_retire, o_instret);
    end
  endtask

  task automatic test_lb();
    int waits_bad;
    apply_reset();
    set_op(3'b001, 3'b000, 2'd2, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    waits_bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (o_ready !== 1'b0 || o_retire !== 1'b0) waits_bad++;
      step();
    end
    total++;
    if (waits_bad != 0) begin
      bad++;
      $display("FAIL lb_wait: got %0d wait cycles with ready/retire high required 0", waits_bad);
    end
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL lb_stall: got ready=%b required 0", o_ready);
    end
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = 32'h1180_FF22;
    step();
    i_dmem_rvalid = 1'b0;
    total++;
    if ({o_ready, o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata} !==
        {1'b1, 1'b1, 1'b1, 5'd7, 32'hFFFF_FF80} || o_instret !== 64'd1) begin
      bad++;
      $display("FAIL lb_commit: got ready=%b retire=%b wen=%b rd=%0d data=%h instret=%0d required 1 1 1 7 ffffff80 1",
               o_ready, o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata, o_instret);
    end
  endtask

  task automatic test_load_sizes();
    logic [2:0]  f3 [5];
    logic [1:0]  lo [5];
    logic [31:0] want [5];
    apply_reset();
    f3[0] = 3'b101; lo[0] = 2'd2; want[0] = 32'h0000_8001;
    f3[1] = 3'b001; lo[1] = 2'd0; want[1] = 32'h0000_1234;
    f3[2] = 3'b010; lo[2] = 2'd1; want[2] = 32'h8001_1234;
    f3[3] = 3'b001; lo[3] = 2'd3; want[3] = 32'hFFFF_8001;
    f3[4] = 3'b100; lo[4] = 2'd3; want[4] = 32'h0000_0080;
    for (int k = 0; k < 5; k++) begin
      do_load(f3[k], lo[k], 5'd12, 32'h8001_1234, k % 2);
      total++;
      if (o_retire !== 1'b1 || o_rd_wdata !== want[k]) begin
        bad++;
        $display("FAIL load_size_%0d: f3=%b lo=%0d got retire=%b data=%h required 1 %h",
                 k, f3[k], lo[k], o_retire, o_rd_wdata, want[k]);
      end
    end
  endtask

  task automatic test_spurious_rvalid();
    apply_reset();
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = 32'hDEAD_BEEF;
    step();
    total++;
    if (o_retire !== 1'b0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL spur_idle: got retire=%b ready=%b required 0 1", o_retire, o_ready);
    end
    set_op(3'b001, 3'b010, 2'd0, 5'd4, 1'b1, 32'h0, 32'h0, 32'h0);
    i_valid = 1'b1;
    i_dmem_rdata = 32'h0000_0077;
    step();
    i_valid = 1'b0;
    i_dmem_rvalid = 1'b0;
    total++;
    if (o_retire !== 1'b0 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL spur_capture: got retire=%b ready=%b required 0 0", o_retire, o_ready);
    end
    step();
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = 32'h0000_0055;
    step();
    i_dmem_rvalid = 1'b0;
    total++;
    if ({o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 1'b1, 5'd4, 32'h0000_0055}
        || o_instret !== 64'd1) begin
      bad++;
      $display("FAIL spur_commit: got retire=%b wen=%b rd=%0d data=%h instret=%0d required 1 1 4 00000055 1",
               o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata, o_instret);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    set_op(3'b001, 3'b010, 2'd0, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_rst = 1'b0;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = 32'h1357_9BDF;
    step();
    i_rst = 1'b1;
    i_dmem_rvalid = 1'b0;
    total++;
    if ({o_retire, o_rd_wen, o_ready} !== 3'b001 || o_instret !== 64'd0) begin
      bad++;
      $display("FAIL rst_wait: got retire=%b wen=%b ready=%b instret=%0d required 0 0 1 0",
               o_retire, o_rd_wen, o_ready, o_instret);
    end
    set_op(3'b000, 3'b010, 2'd0, 5'd8, 1'b0, 32'h0000_4000, 32'h0, 32'h0);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    total++;
    if ({o_retire, o_rd_wen} !== 2'b10 || o_instret !== 64'd1) begin
      bad++;
      $display("FAIL rst_store: got retire=%b wen=%b instret=%0d required 1 0 1",
               o_retire, o_rd_wen, o_instret);
    end
  endtask

  task automatic test_random();
    logic [2:0]  sel, f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        rw, exp_wen;
    logic [31:0] alu, pc4, imm, word, exp_data;
    int          delay, errs_idle;
    apply_reset();
    errs_idle = 0;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom % 3) begin
        i_valid = 1'b0;
        i_dmem_rvalid = 1'($urandom % 2);
        i_dmem_rdata = $urandom;
        step();
        if (o_retire !== 1'b0 || o_rd_wen !== 1'b0) errs_idle++;
      end
      sel = 3'($urandom % 8); f3 = 3'($urandom % 8); lo = 2'($urandom % 4);
      rd = 5'($urandom % 32); rw = 1'($urandom % 2);
      alu = $urandom; pc4 = $urandom; imm = $urandom; word = $urandom;
      set_op(sel, f3, lo, rd, rw, alu, pc4, imm);
      i_valid = 1'b1;
      i_dmem_rvalid = 1'($urandom % 2);
      i_dmem_rdata = $urandom;
      step();
      i_valid = 1'b0;
      i_dmem_rvalid = 1'b0;
      if (sel == 3'd1) begin
        delay = $urandom % 4;
        total++;
        if (o_ready !== 1'b0 || o_retire !== 1'b0) begin
          bad++;
          $display("FAIL rnd_stall_%0d: got ready=%b retire=%b required 0 0", n, o_ready, o_retire);
        end
        repeat (delay) step();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = word;
        step();
        i_dmem_rvalid = 1'b0;
        exp_data = ref_load(word, f3, lo);
      end else if (sel == 3'd2) begin
        exp_data = pc4;
      end else if (sel == 3'd3) begin
        exp_data = imm;
      end else begin
        exp_data = alu;
      end
      exp_wen = rw && (rd != 0);
      exp_instret++;
      total++;
      if ({o_ready, o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 1'b1, exp_wen, rd, exp_data}
          || o_instret !== exp_instret) begin
        bad++;
        $display("FAIL rnd_commit_%0d: sel=%b f3=%b lo=%0d got ready=%b retire=%b wen=%b rd=%0d data=%h instret=%0d required 1 1 %b %0d %h %0d",
                 n, sel, f3, lo, o_ready, o_retire, o_rd_wen, o_rd_waddr, o_rd_wdata, o_instret,
                 exp_wen, rd, exp_data, exp_instret);
      end
    end
    total++;
    if (errs_idle != 0) begin
      bad++;
      $display("FAIL rnd_idle: got %0d idle cycles with retire/wen high required 0", errs_idle);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_lb();
    test_load_sizes();
    test_spurious_rvalid();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
